approx_adder_error_monitor: RTL and testbench

//  Consumer end of the approximate ripple-carry adder datapath. Accepts

---
 rtl/approx_adder_error_monitor.sv | 170 +++++++++++++++++
 tb/tb_approx_adder_error_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_error_monitor.sv
// -----------------------------------------------------------------------------
// approx_adder_error_monitor
//
// Consumer end of the approximate ripple-carry adder datapath. Each accepted
// sample (op_a, op_b, approx_sum) is registered along with its recomputed
// exact sum. On the following edge the error distance is folded into the run
// metrics: error count, saturating sum of error distance, and maximum error
// distance. A run covers a programmed number of samples, then the results
// are held in DONE until the next start.
//
// Ports
//   clk, rst_n    single rising-edge clock, asynchronous active-low reset
//   start         begin a run (honoured in IDLE/DONE only)
//   num_samples   samples per run, latched on an accepted start
//   in_valid      sample on op_a/op_b/approx_sum is valid
//   in_ready      monitor accepts a sample this cycle (RUN only)
//   op_a, op_b    operands fed to the adder under test
//   approx_sum    WIDTH+1-bit sum produced by the adder under test
//   busy          run in progress (RUN or DRAIN)
//   done          results final (DONE)
//   sample_count  samples accepted this run
//   err_count     samples whose approx_sum differed from the exact sum
//   sum_err_dist  saturating sum of |exact - approx_sum|
//   max_err_dist  largest |exact - approx_sum| this run
//   acc_sat       sum_err_dist clamped at all-ones this run (sticky)
// -----------------------------------------------------------------------------
module approx_adder_error_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_err_dist,
  output logic [WIDTH:0]   max_err_dist,
  output logic             acc_sat
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Accumulator arithmetic is done one bit wider than the wider of the
  // accumulator and the error distance so overflow is visible as a carry.
  localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [ACC_W-1:0] sum_err_dist_q, sum_err_dist_d;
  logic [WIDTH:0]   max_err_dist_q, max_err_dist_d;
  logic             acc_sat_q, acc_sat_d;
  logic             stage_valid_q, stage_valid_d;
  logic [WIDTH:0]   exact_q, exact_d;
  logic [WIDTH:0]   approx_q, approx_d;

  logic             transfer;
  logic [WIDTH:0]   ed;
  logic [SUM_W-1:0] acc_sum;

  assign transfer = (state_q == S_RUN) && in_valid;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    n_d            = n_q;
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    sum_err_dist_d = sum_err_dist_q;
    max_err_dist_d = max_err_dist_q;
    acc_sat_d      = acc_sat_q;
    stage_valid_d  = transfer;
    exact_d        = exact_q;
    approx_d       = approx_q;

    ed      = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
    acc_sum = {{(SUM_W - ACC_W){1'b0}}, sum_err_dist_q}
            + {{(SUM_W - WIDTH - 1){1'b0}}, ed};

    if (transfer) begin
      exact_d  = {1'b0, op_a} + {1'b0, op_b};
      approx_d = approx_sum;
    end

    // Stage 2: fold the previously captured sample into the metrics.
    if (stage_valid_q) begin
      if (ed != '0) err_count_d = err_count_q + CNT_W'(1);
      if (acc_sum > ACC_MAX) begin
        sum_err_dist_d = '1;
        acc_sat_d      = 1'b1;
      end else begin
        sum_err_dist_d = acc_sum[ACC_W-1:0];
      end
      if (ed > max_err_dist_q) max_err_dist_d = ed;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d            = num_samples;
          sample_count_d = '0;
          err_count_d    = '0;
          sum_err_dist_d = '0;
          max_err_dist_d = '0;
          acc_sat_d      = 1'b0;
          state_d        = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (transfer) begin
          sample_count_d = sample_count_q + CNT_W'(1);
          if (sample_count_q + CNT_W'(1) == n_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the pipeline stage registers are reset together with the control
  // state so a mid-run reset cannot leave a stale sample to be accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_err_dist_q <= '0;
      max_err_dist_q <= '0;
      acc_sat_q      <= 1'b0;
      stage_valid_q  <= 1'b0;
      exact_q        <= '0;
      approx_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      n_q            <= n_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      sum_err_dist_q <= sum_err_dist_d;
      max_err_dist_q <= max_err_dist_d;
      acc_sat_q      <= acc_sat_d;
      stage_valid_q  <= stage_valid_d;
      exact_q        <= exact_d;
      approx_q       <= approx_d;
    end
  end

  assign in_ready     = (state_q == S_RUN);
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign sum_err_dist = sum_err_dist_q;
  assign max_err_dist = max_err_dist_q;
  assign acc_sat      = acc_sat_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// -----------------------------------------------------------------------------
// Bench for approx_adder_error_monitor. Two instances share all stimulus: one
// with the default 24-bit accumulator and one with a 4-bit accumulator so the
// saturation path can be reached with a few samples. Each accepted sample's
// expected error distance is pushed to a scoreboard queue; when the run
// reaches DONE the queue is drained into expected totals for both instances.
// -----------------------------------------------------------------------------
module tb_approx_adder_error_monitor;

  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int AW  = 24;
  localparam int AWS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_samples;
  logic          in_valid;
  logic [W-1:0]  op_a, op_b;
  logic [W:0]    approx_sum;

  logic          in_ready, busy, done, acc_sat;
  logic [CW-1:0] sample_count, err_count;
  logic [AW-1:0] sum_err_dist;
  logic [W:0]    max_err_dist;

  logic           in_ready_s, busy_s, done_s, acc_sat_s;
  logic [CW-1:0]  sample_count_s, err_count_s;
  logic [AWS-1:0] sum_err_dist_s;
  logic [W:0]     max_err_dist_s;

  int errors = 0;
  int checks = 0;
  int eds[$];

  always #5 clk = ~clk;

  approx_adder_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
    .approx_sum(approx_sum), .busy(busy), .done(done),
    .sample_count(sample_count), .err_count(err_count),
    .sum_err_dist(sum_err_dist), .max_err_dist(max_err_dist), .acc_sat(acc_sat)
  );

  approx_adder_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .op_a(op_a), .op_b(op_b),
    .approx_sum(approx_sum), .busy(busy_s), .done(done_s),
    .sample_count(sample_count_s), .err_count(err_count_s),
    .sum_err_dist(sum_err_dist_s), .max_err_dist(max_err_dist_s),
    .acc_sat(acc_sat_s)
  );

  // All tasks start and end on a falling edge; inputs change there and
  // outputs are sampled there, half a period away from the active edge.
  task automatic pulse_start(input int n);
    num_samples = n[CW-1:0];
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int ap);
    int  ex;
    bit  accepted;
    accepted   = 1'b0;
    op_a       = a[W-1:0];
    op_b       = b[W-1:0];
    approx_sum = ap[W:0];
    in_valid   = 1'b1;
    for (int k = 0; k < 50 && !accepted; k++) begin
      if (in_ready) begin
        ex = a + b;
        eds.push_back((ex >= ap) ? ex - ap : ap - ex);
        accepted = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b after 50 cycles, required 1", in_ready);
    end
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%0b, required 1", name, done);
    end
  endtask

  // Scoreboard drain: pop every expected error distance for this run.
  task automatic sb_compare(input string name, input int n);
    longint sum;
    int     e_err, e_max, ed;
    longint e_big, e_small;
    bit     s_big, s_small;
    sum = 0; e_err = 0; e_max = 0; s_big = 0; s_small = 0;
    e_big = 0; e_small = 0;
    checks++;
    if (eds.size() != n) begin
      errors++;
      $display("FAIL %s_accepted: got %0d transfers, required %0d", name, eds.size(), n);
    end
    while (eds.size() > 0) begin
      ed = eds.pop_front();
      if (ed != 0) e_err++;
      if (ed > e_max) e_max = ed;
      e_big   = e_big + ed;
      e_small = e_small + ed;
      if (e_big   > (64'd1 << AW)  - 1) begin e_big   = (64'd1 << AW)  - 1; s_big   = 1; end
      if (e_small > (64'd1 << AWS) - 1) begin e_small = (64'd1 << AWS) - 1; s_small = 1; end
      sum += ed;
    end
    checks++;
    if (sample_count !== CW'(n)) begin
      errors++;
      $display("FAIL %s_sample_count: got %0d, required %0d", name, sample_count, n);
    end
    checks++;
    if (err_count !== CW'(e_err)) begin
      errors++;
      $display("FAIL %s_err_count: got %0d, required %0d", name, err_count, e_err);
    end
    checks++;
    if (sum_err_dist !== AW'(e_big)) begin
      errors++;
      $display("FAIL %s_sum_err_dist: got %0d, required %0d", name, sum_err_dist, e_big);
    end
    checks++;
    if (max_err_dist !== (W+1)'(e_max)) begin
      errors++;
      $display("FAIL %s_max_err_dist: got %0d, required %0d", name, max_err_dist, e_max);
    end
    checks++;
    if (acc_sat !== s_big) begin
      errors++;
      $display("FAIL %s_acc_sat: got %0b, required %0b", name, acc_sat, s_big);
    end
    checks++;
    if (sum_err_dist_s !== AWS'(e_small)) begin
      errors++;
      $display("FAIL %s_sum_err_dist_acc4: got %0d, required %0d", name, sum_err_dist_s, e_small);
    end
    checks++;
    if (acc_sat_s !== s_small) begin
      errors++;
      $display("FAIL %s_acc_sat_acc4: got %0b, required %0b", name, acc_sat_s, s_small);
    end
    if (sum != 0 && e_err == 0) $display("note: %s nonzero sum with zero errors", name);
  endtask

  task automatic expect_cleared(input string name);
    checks++;
    if ({in_ready, busy, done, acc_sat} !== 4'b0 || sample_count !== '0 ||
        err_count !== '0 || sum_err_dist !== '0 || max_err_dist !== '0 ||
        sum_err_dist_s !== '0 || acc_sat_s !== 1'b0) begin
      errors++;
      $display("FAIL %s_cleared: rdy=%0b busy=%0b done=%0b sat=%0b cnt=%0d err=%0d sum=%0d max=%0d, required all 0",
               name, in_ready, busy, done, acc_sat, sample_count, err_count, sum_err_dist, max_err_dist);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    op_a = '0; op_b = '0; approx_sum = '0;
    repeat (3) @(negedge clk);
    expect_cleared("reset_active");
    rst_n = 1'b1;
    @(negedge clk);
    expect_cleared("reset_release");
    pulse_start(1);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: busy=%0b in_ready=%0b, required 1/1", busy, in_ready);
    end
    send(5, 3, 8);
    wait_done("t1");
    sb_compare("t1", 1);
  endtask

  task automatic test_multi;
    pulse_start(3);
    send(5, 3, 6);
    send(255, 255, 510);
    send(7, 1, 4);
    wait_done("t2");
    repeat (3) @(negedge clk);
    sb_compare("t2", 3);
  endtask

  task automatic test_approx_above;
    pulse_start(1);
    send(0, 0, 7);
    wait_done("t3");
    sb_compare("t3", 1);
  endtask

  task automatic test_back_to_back;
    pulse_start(4);
    send(1, 2, 3);
    @(negedge clk);
    send(10, 20, 31);
    pulse_start(9);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run: busy=%0b rdy=%0b done=%0b, required 1/1/0", busy, in_ready, done);
    end
    send(100, 100, 200);
    repeat (2) @(negedge clk);
    send(200, 100, 44);
    // Keep offering a sample: it must be ignored once in_ready drops.
    in_valid = 1'b1;
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_cycle: done=%0b rdy=%0b busy=%0b, required 0/0/1", done, in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_latency: done=%0b busy=%0b, required 1/0", done, busy);
    end
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    sb_compare("t4", 4);
  endtask

  task automatic test_saturate;
    pulse_start(3);
    for (int i = 0; i < 3; i++) send(0, 0, 7);
    wait_done("t5");
    sb_compare("t5", 3);
    // Restart from DONE with zero samples: stays in DONE, results cleared.
    pulse_start(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum_err_dist !== '0 || acc_sat_s !== 1'b0 ||
        sample_count !== '0 || max_err_dist !== '0) begin
      errors++;
      $display("FAIL done_restart_zero: done=%0b sum=%0d sat4=%0b cnt=%0d, required 1/0/0/0",
               done, sum_err_dist, acc_sat_s, sample_count);
    end
  endtask

  task automatic test_reset_midrun;
    pulse_start(5);
    send(9, 9, 1);
    send(3, 4, 0);
    rst_n = 1'b0;
    #1;
    expect_cleared("midrun_reset");
    eds.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_cleared("midrun_release");
    pulse_start(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_run_done: done=%0b busy=%0b rdy=%0b, required 1/0/0", done, busy, in_ready);
    end
    sb_compare("t6", 0);
  endtask

  initial begin
    test_reset();
    test_multi();
    test_approx_above();
    test_back_to_back();
    test_saturate();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
